ahb_master_protocol_checker: RTL
================================

Name: ahb_master_protocol_checker

Overview:
Synthesizable AHB master-side protocol checker that passively monitors the address and data phases driven by the AHB master BFM. It tracks burst progress, predicts SEQ addresses, and checks control and data stability across wait states. Violations are reported as sticky per-rule flags, a one-cycle pulse and a saturating counter. It sits alongside the slave-side assertions in hdlTop and is bound to the same bus signals.

Parameters:
ADDR_WIDTH, 32, haddr width
DATA_WIDTH, 32, hwdata width (32 or 64)
CNT_WIDTH, 16, err_count width

Ports:
hclk  in  1  bus clock
hreset  in  1  synchronous reset, active-high
haddr  in  ADDR_WIDTH  address
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  write when 1
hsize  in  3  transfer size
hburst  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7
hwdata  in  DATA_WIDTH  write data
hready  in  1  bus-level ready
hresp  in  1  0=OKAY, 1=ERROR
clear  in  1  synchronous clear of flags and counter
err_flags  out  8  sticky per-rule violation bits
err_valid  out  1  one-cycle pulse when any rule fires
err_count  out  CNT_WIDTH  saturating count of violating cycles
burst_active  out  1  fixed-length or INCR burst in progress
beats_left  out  5  remaining SEQ beats of the current fixed burst

Behaviour:
- All outputs are registered and reset to 0. Error state resets to IDLE_ST.
- Accepted transfer = hready && htrans[1]. Stall = !hready.
- FSM IDLE_ST -> BURST_ST on an accepted NONSEQ with hburst!=SINGLE. This latches hsize, hwrite and hburst, and sets beats_left = len-1 (4/8/16 beats; INCR is unbounded, beats_left=0).
- BURST_ST: each accepted SEQ decrements beats_left. The last fixed beat, an accepted NONSEQ or an accepted IDLE leaves the state (a new NONSEQ re-enters).
- Any state -> ERR_ST on hresp && !hready (first ERROR cycle). ERR_ST -> IDLE_ST on the next cycle with hready. The burst is abandoned with no BURST_LEN violation.
- Next-address prediction: bytes = 1<<hsize.
  - INCR*: next = addr + bytes.
  - WRAPn: bound = n*bytes; next = (addr & ~(bound-1)) | ((addr+bytes) & (bound-1)).
  - Updated on every accepted NONSEQ/SEQ. BUSY holds the prediction.
- Rules (err_flags bit):
  - 0 CTRL_HOLD: prev cycle stalled with htrans[1], and this cycle haddr, hwrite, hsize, hburst or htrans changed. Exceptions: BUSY->SEQ is allowed; not checked while in ERR_ST.
  - 1 WDATA_HOLD: write data phase stalled in the prev cycle, and hwdata differs from the prev cycle.
  - 2 SEQ_OUTSIDE: htrans SEQ/BUSY while in IDLE_ST.
  - 3 SEQ_MISMATCH: accepted SEQ with haddr != predicted address, or hsize/hwrite/hburst != latched values.
  - 4 BURST_LEN: fixed burst with beats_left>0 ended by NONSEQ/IDLE, or SEQ with beats_left==0 on a fixed burst.
  - 5 UNALIGNED: htrans[1] && haddr mod bytes != 0.
  - 6 HSIZE_WIDE: htrans[1] && bytes > DATA_WIDTH/8.
  - 7 KB_CROSS: INCR-type SEQ whose predicted address crosses a 1 KB boundary relative to the previous beat.
- Detection timing: a violation sampled at edge N sets its flag bit(s) and err_valid in the outputs after edge N. err_valid drops next cycle unless another violation occurs.
- err_count increments by 1 per violating cycle regardless of bit count, saturating at all-ones.
- clear and a violation in the same cycle: the violation's bits and a count of 1 remain.
- Hold rules 0/1 are suppressed on the first cycle after reset release (no history).
- hreset mid-burst returns to IDLE_ST and clears everything. A SEQ on the first active cycle after reset flags bit 2.

Test Plan:
1. INCR4 word burst at 0x100, 0x104, 0x108, 0x10C with 2 wait states on beat 2, signals held -> err_flags=0, err_count=0, beats_left 3,2,1,0.
2. WRAP4 word at 0x38 -> expect 0x3C, 0x30, 0x34. Driving 0x40 as beat 2 -> err_flags[3]=1, err_valid pulse 1 cycle, err_count=1.
3. Write stall where haddr of the next NONSEQ changes 0x200->0x204 and hwdata changes during the stall -> bits 0 and 1 set in the same cycle, err_count=1.
4. INCR8 ended after 3 beats by NONSEQ -> bit 4. Repeat with a two-cycle ERROR on beat 3 -> no bit 4, FSM back to IDLE_ST.
5. NONSEQ hsize=2 at 0x102 -> bit 5. Then INCR word burst 0x3F8, 0x3FC, 0x400 -> bit 7 on the third beat.
6. Flags set then clear asserted -> all 0. Clear coincident with SEQ in IDLE_ST -> err_flags=0x04, err_count=1. hreset mid-INCR16 -> burst_active=0, beats_left=0.

Source files
------------

// File: rtl/ahb_master_protocol_checker.sv
// ahb_master_protocol_checker: passive AHB master-side protocol checker with sticky rule flags, pulse and count
// Ports: hclk/hreset bus clock and synchronous active-high reset; haddr, htrans, hwrite, hsize, hburst,
// hwdata, hready, hresp are the monitored bus; clear wipes flags and count; err_flags holds sticky rule
// bits; err_valid pulses on any violating cycle; err_count saturates; burst_active/beats_left track bursts.
module ahb_master_protocol_checker #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic                  clear,
  output logic [7:0]            err_flags,
  output logic                  err_valid,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  burst_active,
  output logic [4:0]            beats_left
);
  localparam logic [1:0] IDLE_ST = 2'd0, BURST_ST = 2'd1, ERR_ST = 2'd2;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_SEQ = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
  logic [1:0] state, state_nx;
  logic [4:0] left_nx;
  logic [2:0] lat_size, lat_burst;
  logic lat_write, acc, in_burst, lat_fixed;
  logic [ADDR_WIDTH-1:0] pred, bytes, bound, next_addr;
  logic [ADDR_WIDTH-11:0] last_kb;
  logic [ADDR_WIDTH+8:0] ctrl, ctrl_q;
  logic [DATA_WIDTH-1:0] hwdata_q;
  logic hist, stall_ctrl_q, wdp, wstall_q;
  logic [7:0] viol;
  always_comb begin
    acc = hready && htrans[1];
    in_burst = state == BURST_ST;
    lat_fixed = lat_burst[2:1] != 2'd0;
    ctrl = {haddr, hwrite, hsize, hburst, htrans};
    bytes = ONE << hsize;
    bound = bytes << ({1'b0, hburst[2:1]} + 3'd1);
    next_addr = (hburst != 3'd0 && !hburst[0]) ? ((haddr & ~(bound - ONE)) | ((haddr + bytes) & (bound - ONE)))
                                                : haddr + bytes;
    viol[0] = hist && stall_ctrl_q && state != ERR_ST && ctrl != ctrl_q && !(ctrl_q[1:0] == T_BUSY && htrans == T_SEQ);
    viol[1] = hist && wstall_q && hwdata != hwdata_q;
    viol[2] = state == IDLE_ST && htrans[0];
    viol[3] = in_burst && acc && htrans[0] &&
              (haddr != pred || hsize != lat_size || hwrite != lat_write || hburst != lat_burst);
    // NONSEQ/IDLE (htrans[0]==0) ends a fixed burst early; an extra SEQ overruns it
    viol[4] = in_burst && lat_fixed && hready && (htrans[0] ? htrans[1] && beats_left == 5'd0 : beats_left != 5'd0);
    viol[5] = htrans[1] && (haddr & (bytes - ONE)) != '0;
    viol[6] = htrans[1] && hsize > MAX_SIZE;
    viol[7] = in_burst && acc && htrans[0] && lat_burst[0] && pred[ADDR_WIDTH-1:10] != last_kb;
    state_nx = state;
    left_nx = beats_left;
    if (hresp && !hready) begin
      state_nx = ERR_ST;
      left_nx = 5'd0;
    end else if (state == ERR_ST) begin
      state_nx = hready ? IDLE_ST : ERR_ST;
      left_nx = 5'd0;
    end else if (acc && !htrans[0]) begin
      state_nx = hburst != 3'd0 ? BURST_ST : IDLE_ST;
      left_nx = hburst[2:1] == 2'd0 ? 5'd0 : (5'd2 << hburst[2:1]) - 5'd1;
    end else if (in_burst && acc) begin
      state_nx = lat_fixed && beats_left <= 5'd1 ? IDLE_ST : BURST_ST;
      left_nx = lat_fixed && beats_left != 5'd0 ? beats_left - 5'd1 : 5'd0;
    end else if (hready && htrans == T_IDLE) begin
      state_nx = IDLE_ST;
      left_nx = 5'd0;
    end
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= IDLE_ST;
      beats_left <= '0;
      burst_active <= 1'b0;
      err_flags <= '0;
      err_valid <= 1'b0;
      err_count <= '0;
      lat_size <= '0;
      lat_write <= 1'b0;
      lat_burst <= '0;
      pred <= '0;
      last_kb <= '0;
      hist <= 1'b0;
      stall_ctrl_q <= 1'b0;
      wdp <= 1'b0;
      wstall_q <= 1'b0;
      ctrl_q <= '0;
      hwdata_q <= '0;
    end else begin
      state <= state_nx;
      beats_left <= left_nx;
      burst_active <= state_nx == BURST_ST;
      err_flags <= (clear ? 8'd0 : err_flags) | viol;
      err_valid <= |viol;
      err_count <= clear ? CNT_WIDTH'(|viol) : err_count + CNT_WIDTH'(|viol && err_count != '1);
      if (acc && !htrans[0]) {lat_size, lat_write, lat_burst} <= {hsize, hwrite, hburst};
      if (acc) begin
        pred <= next_addr;
        last_kb <= haddr[ADDR_WIDTH-1:10];
      end
      hist <= 1'b1;
      stall_ctrl_q <= !hready && htrans[1];
      wdp <= hready ? acc && hwrite : wdp;
      wstall_q <= wdp && !hready;
      ctrl_q <= ctrl;
      hwdata_q <= hwdata;
    end
  end
endmodule
